mem_byte_sequencer: RTL and testbench

Memory-stage access controller between the EXE/MEM pipeline register and the byte-wide data memory. It turns each 32-bit load or store into four sequential byte accesses in little-endian order, one byte per cycle. It assembles load words and holds `freeze` high so the pipeline stalls until the word access completes. Non-memory instructions pass with zero stall.

---
 rtl/mem_byte_sequencer.sv | 163 ++++++++++++++++
 tb/tb_mem_byte_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mem_byte_sequencer
// Brief    : Splits 32-bit loads/stores into four little-endian byte accesses,
//            stalling the pipeline via freeze. Option macro: ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module mem_byte_sequencer #(
   parameter int ADDR_BITS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ALU_result,
   input  logic [31:0] ST_val,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   output logic        freeze,
   output logic [31:0] MEM_result,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_r_en,
   output logic        mem_w_en,
   input  logic [31:0] mem_rdata,
   output logic        misalign
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [1:0]            r_k;
   logic [ADDR_BITS-1:0]  r_base;
   logic [31:0]           r_st_val;
   logic                  r_is_store;
   logic [23:0]           r_shadow;
   logic [31:0]           r_mem_result;

   logic                  w_req;
   logic                  w_misalign;
   logic                  w_accept;
   logic                  w_freeze;
   logic                  w_mem_r_en;
   logic                  w_mem_w_en;
   logic [ADDR_BITS-1:0]  w_addr;
   logic [31:0]           w_mem_addr;
   logic [7:0]            w_byte;
   logic [31:0]           w_mem_wdata;
   logic                  w_unused_ok;

   assign w_req = MEM_R_EN | MEM_W_EN;

`ifdef ALIGN_CHECK_EN
   assign w_misalign = (r_state == S_IDLE) & w_req & (|ALU_result[1:0]);
`else
   assign w_misalign = 1'b0;
`endif

   // A misaligned request (when checked) is dropped rather than sequenced.
   assign w_accept = (r_state == S_IDLE) & w_req & ~w_misalign;

   assign w_addr = r_base + ADDR_BITS'(r_k);

   always_comb begin
      w_byte = r_st_val[7:0];
      case (r_k)
         2'd0:    w_byte = r_st_val[7:0];
         2'd1:    w_byte = r_st_val[15:8];
         2'd2:    w_byte = r_st_val[23:16];
         2'd3:    w_byte = r_st_val[31:24];
         default: w_byte = r_st_val[7:0];
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_freeze    = 1'b0;
      w_mem_r_en  = 1'b0;
      w_mem_w_en  = 1'b0;
      w_mem_addr  = 32'd0;
      w_mem_wdata = 32'd0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next   = S_ACCESS;
               w_freeze = 1'b1;
            end
         end
         S_ACCESS: begin
            w_freeze    = 1'b1;
            w_mem_r_en  = ~r_is_store;
            w_mem_w_en  = r_is_store;
            w_mem_addr  = 32'(w_addr);
            w_mem_wdata = r_is_store ? {24'd0, w_byte} : 32'd0;
            if (r_k == 2'd3) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            // Same instruction still sits in EXE/MEM here, so requests are ignored.
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_k          <= 2'd0;
         r_base       <= '0;
         r_st_val     <= 32'd0;
         r_is_store   <= 1'b0;
         r_shadow     <= 24'd0;
         r_mem_result <= 32'd0;
      end else begin
         if (w_accept) begin
            r_base     <= ALU_result[ADDR_BITS-1:0];
            r_st_val   <= ST_val;
            r_is_store <= MEM_W_EN;
            r_k        <= 2'd0;
         end
         if (r_state == S_ACCESS) begin
            r_k <= r_k + 2'd1;
            if (!r_is_store) begin
               case (r_k)
                  2'd0:    r_shadow[7:0]   <= mem_rdata[7:0];
                  2'd1:    r_shadow[15:8]  <= mem_rdata[7:0];
                  2'd2:    r_shadow[23:16] <= mem_rdata[7:0];
                  // Last byte goes straight into the result so it is valid in DONE.
                  2'd3:    r_mem_result    <= {mem_rdata[7:0], r_shadow};
                  default: r_shadow        <= r_shadow;
               endcase
            end
         end
      end
   end

   // freeze/misalign are partly combinational on the request; force them low in reset.
   assign freeze     = w_freeze & rst;
   assign misalign   = w_misalign & rst;
   assign mem_r_en   = w_mem_r_en;
   assign mem_w_en   = w_mem_w_en;
   assign mem_addr   = w_mem_addr;
   assign mem_wdata  = w_mem_wdata;
   assign MEM_result = r_mem_result;

   assign w_unused_ok = ^{ALU_result, mem_rdata[31:8]};

endmodule
`default_nettype wire

// File: tb/tb_mem_byte_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_mem_byte_sequencer
// Brief    : Directed, table-driven bench with a byte-wide memory model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mem_byte_sequencer;

   logic        clk;
   logic        rst;
   logic [31:0] ALU_result;
   logic [31:0] ST_val;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic        freeze;
   logic [31:0] MEM_result;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] mem_rdata;
   logic        misalign;

   logic [7:0]  mem [256];
   logic [7:0]  exp_mem [256];
   logic        pl_en;
   logic [7:0]  pl_addr;
   logic [7:0]  pl_data;

   int          total;
   int          bad;
   logic [31:0] exp_res;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] stv;
      logic [31:0] exp_res;
      logic        wrap;
   } vec_t;

   vec_t vecs[8];

   mem_byte_sequencer #(.ADDR_BITS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .ALU_result (ALU_result),
      .ST_val     (ST_val),
      .MEM_R_EN   (MEM_R_EN),
      .MEM_W_EN   (MEM_W_EN),
      .freeze     (freeze),
      .MEM_result (MEM_result),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_r_en   (mem_r_en),
      .mem_w_en   (mem_w_en),
      .mem_rdata  (mem_rdata),
      .misalign   (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = {24'hABCDEF, mem[mem_addr[7:0]]};

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (mem_w_en) mem[mem_addr[7:0]] <= mem_wdata[7:0];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_r_en"},  32'(mem_r_en),  32'd0);
      chk({tag, "_w_en"},  32'(mem_w_en),  32'd0);
      chk({tag, "_addr"},  mem_addr,       32'd0);
      chk({tag, "_wdata"}, mem_wdata,      32'd0);
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0] a;
      logic [7:0] b;
      logic [31:0] sv;
      @(negedge clk);
      ALU_result = v.addr; ST_val = v.stv; MEM_R_EN = v.rd; MEM_W_EN = v.wr;
      #1;
      chk("misalign_T", 32'(misalign), 32'd0);
      if (!(v.rd | v.wr)) begin
         chk("nomem_freeze", 32'(freeze), 32'd0);
         chk_idle_outputs("nomem");
         chk("nomem_result", MEM_result, v.exp_res);
         @(negedge clk);
         #1;
         chk("nomem_freeze2", 32'(freeze), 32'd0);
         chk_idle_outputs("nomem2");
      end else begin
         chk("req_freeze", 32'(freeze), 32'd1);
         chk_idle_outputs("req");
         sv = v.stv;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            a = 8'(v.addr + 32'(i));
            b = 8'(sv >> (8 * i));
            chk("acc_freeze", 32'(freeze), 32'd1);
            chk("acc_addr", mem_addr, {24'd0, a});
            chk("acc_r_en", 32'(mem_r_en), 32'(!v.wr));
            chk("acc_w_en", 32'(mem_w_en), 32'(v.wr));
            chk("acc_wdata", mem_wdata, v.wr ? {24'd0, b} : 32'd0);
            if (v.wr) exp_mem[a] = b;
         end
         @(negedge clk);
         #1;
         chk("done_freeze", 32'(freeze), 32'd0);
         chk_idle_outputs("done");
         chk("done_result", MEM_result, v.exp_res);
         @(negedge clk);
         ALU_result = 32'd0; ST_val = 32'd0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
         #1;
         chk("after_freeze", 32'(freeze), 32'd0);
         chk("after_result", MEM_result, v.exp_res);
         for (int i = 0; i < 4; i++) begin
            a = 8'(v.addr + 32'(i));
            chk("mem_byte", {24'd0, mem[a]}, {24'd0, exp_mem[a]});
         end
      end
      exp_res = v.exp_res;
   endtask

   initial begin
      vec_t rv;
      total = 0; bad = 0;
      vecs[0] = '{rd:1'b1, wr:1'b0, addr:32'd100, stv:32'h0,        exp_res:32'h000100FF, wrap:1'b0};
      vecs[1] = '{rd:1'b0, wr:1'b1, addr:32'd8,   stv:32'hDEADBEEF, exp_res:32'h000100FF, wrap:1'b0};
      vecs[2] = '{rd:1'b1, wr:1'b0, addr:32'd8,   stv:32'h0,        exp_res:32'hDEADBEEF, wrap:1'b0};
      vecs[3] = '{rd:1'b0, wr:1'b1, addr:32'd254, stv:32'h11223344, exp_res:32'hDEADBEEF, wrap:1'b1};
      vecs[4] = '{rd:1'b1, wr:1'b0, addr:32'd254, stv:32'h0,        exp_res:32'h11223344, wrap:1'b1};
      vecs[5] = '{rd:1'b1, wr:1'b1, addr:32'd40,  stv:32'hCAFEF00D, exp_res:32'h11223344, wrap:1'b0};
      vecs[6] = '{rd:1'b0, wr:1'b0, addr:32'd44,  stv:32'h12345678, exp_res:32'h11223344, wrap:1'b0};
      vecs[7] = '{rd:1'b1, wr:1'b0, addr:32'd40,  stv:32'h0,        exp_res:32'hCAFEF00D, wrap:1'b0};

      rst = 1'b0; ALU_result = 32'd0; ST_val = 32'd0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
      pl_en = 1'b0; pl_addr = 8'd0; pl_data = 8'd0;
      exp_res = 32'd0;
      for (int i = 0; i < 256; i++) exp_mem[i] = 8'd0;
      exp_mem[100] = 8'hFF; exp_mem[101] = 8'h00; exp_mem[102] = 8'h01; exp_mem[103] = 8'h00;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         pl_en = 1'b1; pl_addr = 8'(i); pl_data = exp_mem[i];
      end
      @(negedge clk);
      pl_en = 1'b0;
      #1;
      chk("rst_freeze", 32'(freeze), 32'd0);
      chk("rst_result", MEM_result, 32'd0);
      chk("rst_misalign", 32'(misalign), 32'd0);
      chk_idle_outputs("rst");
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 8; i++) begin
         rv = vecs[i];
`ifdef ALIGN_CHECK_EN
         if (!rv.wrap) run_vec(rv);
`else
         run_vec(rv);
`endif
      end

      // Reset in the middle of a store: bytes 0-1 land, bytes 2-3 never do.
      @(negedge clk);
      ALU_result = 32'd60; ST_val = 32'hA5B6C7D8; MEM_W_EN = 1'b1; MEM_R_EN = 1'b0;
      #1;
      chk("mid_req_freeze", 32'(freeze), 32'd1);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("mid_k2_w_en", 32'(mem_w_en), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_freeze", 32'(freeze), 32'd0);
      chk("mid_rst_result", MEM_result, 32'd0);
      chk("mid_rst_misalign", 32'(misalign), 32'd0);
      chk_idle_outputs("mid_rst");
      exp_mem[60] = 8'hD8; exp_mem[61] = 8'hC7;
      @(negedge clk);
      ALU_result = 32'd0; ST_val = 32'd0; MEM_W_EN = 1'b0;
      for (int i = 60; i < 64; i++) chk("mid_mem", {24'd0, mem[i]}, {24'd0, exp_mem[i]});
      rst = 1'b1;
      rv = '{rd:1'b1, wr:1'b0, addr:32'd60, stv:32'h0, exp_res:32'h0000C7D8, wrap:1'b0};
      run_vec(rv);

`ifdef ALIGN_CHECK_EN
      @(negedge clk);
      ALU_result = 32'd101; MEM_R_EN = 1'b1;
      #1;
      chk("mis_flag", 32'(misalign), 32'd1);
      chk("mis_freeze", 32'(freeze), 32'd0);
      chk_idle_outputs("mis");
      @(negedge clk);
      ALU_result = 32'd0; MEM_R_EN = 1'b0;
      #1;
      chk("mis_flag_clr", 32'(misalign), 32'd0);
      chk("mis_freeze2", 32'(freeze), 32'd0);
      chk_idle_outputs("mis2");
      chk("mis_result", MEM_result, exp_res);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
